frame_capture_ctrl: RTL and testbench

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/cam_pkg.sv | 14 +
 rtl/sync_edge.sv | 29 ++
 rtl/frame_capture_ctrl.sv | 138 +++++++++++++
 tb/tb_frame_capture_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera frame-capture block.
package cam_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int H_PIXELS_DEF = 160;
  localparam int V_LINES_DEF  = 120;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous camera sync line, with
// single-cycle rise/fall pulses derived from the synchronized copy.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // s1/s2 resolve metastability; s3 is the previous synchronized value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: arms on request, captures one frame between
// VSYNC falling and rising edges, writes pixels to a linear frame buffer.
// Optional macro FRAME_CAPTURE_STATS_EN enables the completed-frame counter;
// without it FRAME_CNT is tied to zero.
module frame_capture_ctrl
  import cam_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int ADDR_W   = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic              ARM,
  input  logic              CONT,
  input  logic              READY_COLOR,
  input  logic              ACK,
  output logic              START,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              FRAME_DONE,
  output logic              BUSY,
  output logic              ERR,
  output logic [15:0]       FRAME_CNT
);

  // col and line saturate at H_PIXELS / V_LINES since dropped pixels never advance them
  localparam int COL_W  = $clog2(H_PIXELS + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);

  cap_state_t        state;
  logic [COL_W-1:0]  col, col_inc;
  logic [LINE_W-1:0] line, line_nxt;
  logic [ADDR_W-1:0] base;
  logic              frame_err;
  logic              vs_rise, vs_fall, hs_rise, hs_fall;
  logic              px_ok, px_drop, line_step;

  sync_edge u_vs (.clk(CLK), .rst(RST), .din(VSYNC), .rise(vs_rise), .fall(vs_fall));
  sync_edge u_hs (.clk(CLK), .rst(RST), .din(HREF),  .rise(hs_rise), .fall(hs_fall));

  // pixel accept/drop and the line advance; a pixel coinciding with HREF fall counts toward the line
  always_comb begin
    px_ok   = 1'b0;
    px_drop = 1'b0;
    if (state == CAPTURE && READY_COLOR) begin
      if (col < COL_W'(H_PIXELS) && line < LINE_W'(V_LINES)) px_ok = 1'b1;
      else                                                   px_drop = 1'b1;
    end
    col_inc   = col + COL_W'(px_ok);
    line_step = hs_fall && (col_inc != '0);
    line_nxt  = line + LINE_W'(line_step);
  end

  // main FSM with registered outputs; base tracks line*H_PIXELS without a multiplier
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      col        <= '0;
      line       <= '0;
      base       <= '0;
      frame_err  <= 1'b0;
      START      <= 1'b0;
      WE         <= 1'b0;
      ADDR       <= '0;
      FRAME_DONE <= 1'b0;
      BUSY       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      WE <= 1'b0;
      case (state)
        IDLE: begin
          if (ARM) begin
            state <= WAIT_VS;
            BUSY  <= 1'b1;
          end
        end
        WAIT_VS: begin
          if (vs_fall) begin
            state     <= CAPTURE;
            START     <= 1'b1;
            col       <= '0;
            line      <= '0;
            base      <= '0;
            frame_err <= 1'b0;
            ERR       <= 1'b0;
          end
        end
        CAPTURE: begin
          if (px_ok) begin
            WE   <= 1'b1;
            ADDR <= base + ADDR_W'(col);
          end
          col  <= hs_fall ? '0 : col_inc;
          line <= line_nxt;
          if (line_step) base <= base + ADDR_W'(H_PIXELS);
          if (px_drop) frame_err <= 1'b1;
          if (vs_rise) begin
            state      <= DONE;
            START      <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b1;
            ERR        <= frame_err | px_drop | (line_nxt != LINE_W'(V_LINES));
          end
        end
        DONE: begin
          // a VSYNC fall in this cycle is ignored; a fresh one is needed in WAIT_VS
          if (ACK) begin
            FRAME_DONE <= 1'b0;
            if (CONT) begin
              state <= WAIT_VS;
              BUSY  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_CAPTURE_STATS_EN
  logic done_entry;
  assign done_entry = (state == CAPTURE) && vs_rise;

  // completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             FRAME_CNT <= 16'd0;
    else if (done_entry) FRAME_CNT <= FRAME_CNT + 16'd1;
  end
`else
  assign FRAME_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Bench for frame_capture_ctrl at 4x3 geometry: table of frame shapes,
// WE/ADDR scoreboard, plus hand sequences for CONT, ACK/VSYNC collision and reset.
module tb_frame_capture_ctrl;

  localparam int HP = 4;
  localparam int VL = 3;
  localparam int AW = 4;
`ifdef FRAME_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST, VSYNC, HREF, ARM, CONT, READY_COLOR, ACK;
  logic          START, WE, FRAME_DONE, BUSY, ERR;
  logic [AW-1:0] ADDR;
  logic [15:0]   FRAME_CNT;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int we_seen = 0;
  int last_addr = -1;
  int exp_cnt = 0;

  frame_capture_ctrl #(.H_PIXELS(HP), .V_LINES(VL), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .VSYNC(VSYNC), .HREF(HREF), .ARM(ARM), .CONT(CONT),
    .READY_COLOR(READY_COLOR), .ACK(ACK), .START(START), .WE(WE), .ADDR(ADDR),
    .FRAME_DONE(FRAME_DONE), .BUSY(BUSY), .ERR(ERR), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int               lines;
    logic [3:0][3:0]  px;       // pixels per line, px[0] is the first line
    bit               exp_err;
    int               exp_we;
    int               exp_last;
  } vec_t;

  vec_t tbl[5];

  // scoreboard: every WE must match the oldest expected address
  always @(negedge CLK) begin
    int e;
    if (RST === 1'b0 && WE === 1'b1) begin
      we_seen++;
      last_addr = int'(ADDR);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_we: addr %0d written, expected no write", ADDR);
      end else begin
        e = exp_q.pop_front();
        if (int'(ADDR) != e) begin
          errors++;
          $display("FAIL we_addr: got %0d expected %0d", ADDR, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pixel(input int l, input int c);
    READY_COLOR = 1'b1;
    if (c < HP && l < VL) exp_q.push_back(l * HP + c);
    tick();
    READY_COLOR = 1'b0;
    tick();
  endtask

  task automatic arm();
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    chk("busy_after_arm", BUSY, 1);
  endtask

  task automatic ack_frame(input bit cont);
    CONT = cont;
    ACK  = 1'b1;
    tick();
    ACK  = 1'b0;
    chk("frame_done_after_ack", FRAME_DONE, 0);
    chk("busy_after_ack", BUSY, cont);
  endtask

  task automatic run_frame(input int idx);
    int ml;
    ml = 0;
    we_seen = 0;
    last_addr = -1;
    VSYNC = 1'b1; tick(6);
    VSYNC = 1'b0; tick(6);
    chk("start_in_capture", START, 1);
    chk("busy_in_capture", BUSY, 1);
    chk("err_cleared_on_capture", ERR, 0);
    for (int l = 0; l < tbl[idx].lines; l++) begin
      HREF = 1'b1; tick(2);
      for (int p = 0; p < int'(tbl[idx].px[l]); p++) pixel(ml, p);
      HREF = 1'b0; tick(6);
      if (tbl[idx].px[l] != 4'd0) ml++;
    end
    VSYNC = 1'b1; tick(6);
    exp_cnt++;
    chk("frame_done", FRAME_DONE, 1);
    chk("frame_err", ERR, tbl[idx].exp_err);
    chk("busy_in_done", BUSY, 0);
    chk("start_in_done", START, 0);
    chk("we_count", we_seen, tbl[idx].exp_we);
    chk("last_addr", last_addr, tbl[idx].exp_last);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frame_cnt", FRAME_CNT, STATS ? exp_cnt : 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, START, 0);
    chk({tag, "_we"}, WE, 0);
    chk({tag, "_addr"}, ADDR, 0);
    chk({tag, "_frame_done"}, FRAME_DONE, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_err"}, ERR, 0);
    chk({tag, "_frame_cnt"}, FRAME_CNT, 0);
  endtask

  initial begin
    //          lines  px per line (line3..line0)        err  we  last
    tbl[0] = '{3, {4'd0, 4'd4, 4'd4, 4'd4}, 1'b0, 12, 11};  // clean 4x3
    tbl[1] = '{3, {4'd0, 4'd4, 4'd4, 4'd6}, 1'b1, 12, 11};  // overlong first line
    tbl[2] = '{2, {4'd0, 4'd0, 4'd4, 4'd4}, 1'b1,  8,  7};  // short frame
    tbl[3] = '{3, {4'd0, 4'd2, 4'd4, 4'd4}, 1'b0, 10,  9};  // short last line is fine
    tbl[4] = '{4, {4'd3, 4'd4, 4'd4, 4'd4}, 1'b1, 12, 11};  // extra line dropped

    RST = 1'b1; VSYNC = 1'b0; HREF = 1'b0; ARM = 1'b0; CONT = 1'b0;
    READY_COLOR = 1'b0; ACK = 1'b0;
    tick(3);
    chk_all_zero("reset");
    RST = 1'b0;
    tick(2);
    chk("idle_not_busy", BUSY, 0);

    // table-driven frames, single-shot
    for (int i = 0; i < 5; i++) begin
      arm();
      run_frame(i);
      ack_frame(1'b0);
    end

    // ARM outside IDLE is ignored: ARM during DONE must not re-arm after ACK
    arm();
    run_frame(0);
    ARM = 1'b1; tick(); ARM = 1'b0;
    ack_frame(1'b0);
    tick(2);
    chk("arm_in_done_ignored", BUSY, 0);

    // continuous mode: ACK with CONT goes straight back to WAIT_VS
    arm();
    run_frame(0);
    ack_frame(1'b1);
    run_frame(3);

    // ACK coincides with a synchronized VSYNC fall: re-arm but do not capture
    VSYNC = 1'b0;
    tick();
    tick();
    CONT = 1'b1; ACK = 1'b1;
    tick();
    ACK = 1'b0;
    chk("collide_busy", BUSY, 1);
    chk("collide_frame_done", FRAME_DONE, 0);
    we_seen = 0;
    tick(4);
    chk("collide_no_start", START, 0);
    HREF = 1'b1; tick(2);
    READY_COLOR = 1'b1; tick(); READY_COLOR = 1'b0; tick(3);
    HREF = 1'b0; tick(2);
    chk("collide_no_we", we_seen, 0);
    run_frame(0);
    ack_frame(1'b0);

    // reset in the middle of capture drops the frame
    arm();
    VSYNC = 1'b1; tick(6);
    VSYNC = 1'b0; tick(6);
    HREF = 1'b1; tick(2);
    for (int p = 0; p < 4; p++) pixel(0, p);
    HREF = 1'b0; tick(6);
    HREF = 1'b1; tick(2);
    pixel(1, 0);
    RST = 1'b1;
    tick();
    exp_q.delete();
    exp_cnt = 0;
    chk_all_zero("midreset");
    RST = 1'b0; HREF = 1'b0;
    tick(2);

    // VSYNC activity without ARM captures nothing
    we_seen = 0;
    VSYNC = 1'b1; tick(6);
    VSYNC = 1'b0; tick(6);
    HREF = 1'b1; tick(2);
    READY_COLOR = 1'b1; tick(); READY_COLOR = 1'b0; tick();
    READY_COLOR = 1'b1; tick(); READY_COLOR = 1'b0; tick();
    HREF = 1'b0; tick(4);
    VSYNC = 1'b1; tick(6);
    chk("noarm_we", we_seen, 0);
    chk("noarm_busy", BUSY, 0);
    chk("noarm_start", START, 0);
    chk("noarm_frame_done", FRAME_DONE, 0);

    // capture resumes only after a new ARM
    arm();
    run_frame(0);
    ack_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
